// File: rtl/id_pipe_if.sv
// id_pipe_if: upstream instruction handshake and registered decode results of the decode stage.
interface id_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int INST_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst_i;
  logic [31:0]       pc_i;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic              illegal_o;
  logic [31:0]       pc_o;
  modport master (
    output in_valid, inst_i, pc_i, out_ready,
    input  in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, illegal_o, pc_o
  );
  modport slave (
    input  in_valid, inst_i, pc_i, out_ready,
    output in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, illegal_o, pc_o
  );
endinterface

// File: rtl/id_pipe.sv
// id_pipe: instruction decode stage with operand forwarding, load-use stall and a one-deep output register.
module id_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int INST_W = 64,
  parameter int NFWD   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  id_pipe_if.slave                 bus,
  output logic                     reg1_read_o,
  output logic                     reg2_read_o,
  output logic [REG_AW-1:0]        reg1_addr_o,
  output logic [REG_AW-1:0]        reg2_addr_o,
  input  logic [DATA_W-1:0]        reg1_data_i,
  input  logic [DATA_W-1:0]        reg2_data_i,
  input  logic [NFWD-1:0]          fwd_wreg_i,
  input  logic [NFWD*REG_AW-1:0]   fwd_wd_i,
  input  logic [NFWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic                     ex_is_load_i,
  input  logic                     flush_i,
  output logic [CNT_W-1:0]         hazard_cnt_o
);
  localparam logic [3:0] MEM_SREG      = 4'h1;
  localparam logic [3:0] MEM_DREG      = 4'h2;
  localparam logic [7:0] EXE_NOP_OP    = 8'h00;
  localparam logic [7:0] EXE_AND_OP    = 8'h24;
  localparam logic [7:0] EXE_OR_OP     = 8'h25;
  localparam logic [7:0] EXE_XOR_OP    = 8'h26;
  localparam logic [7:0] EXE_NOT_OP    = 8'h27;
  localparam logic [7:0] EXE_SHL_OP    = 8'h7c;
  localparam logic [7:0] EXE_SHR_OP    = 8'h02;
  localparam logic [7:0] EXE_SAR_OP    = 8'h03;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;

  logic [3:0]        mem;
  logic [7:0]        op;
  logic [REG_AW-1:0] wd, rs1, rs2, fwd0_wd;
  logic              is_sreg, is_logic, is_shift, is_not, legal, hazard, xfer;
  logic [DATA_W-1:0] imm1, imm2, op1, op2;

  assign mem      = bus.inst_i[63:60];
  assign op       = bus.inst_i[59:52];
  assign wd       = REG_AW'(bus.inst_i[51:47]);
  assign rs1      = REG_AW'(bus.inst_i[46:42]);
  assign rs2      = REG_AW'(bus.inst_i[41:37]);
  assign is_sreg  = mem == MEM_SREG;
  assign is_not   = op == EXE_NOT_OP;
  assign is_logic = op == EXE_OR_OP || op == EXE_AND_OP || op == EXE_XOR_OP || is_not;
  assign is_shift = op == EXE_SHL_OP || op == EXE_SHR_OP || op == EXE_SAR_OP;
  assign legal    = (is_sreg || mem == MEM_DREG) && (is_logic || is_shift);

  assign reg1_read_o = legal && !(is_sreg && is_not);
  assign reg2_read_o = legal && !is_sreg && !is_not;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;
  assign imm1 = (legal && is_sreg && is_not) ? DATA_W'(bus.inst_i[46:16]) : '0;
  assign imm2 = !(legal && is_sreg) ? '0 :
                op == EXE_SAR_OP ? DATA_W'(bus.inst_i[41:37]) : DATA_W'(bus.inst_i[41:10]);

  // Walk sources from lowest priority upward so index 0 (EX) overwrites last.
  always_comb begin
    op1 = reg1_data_i;
    op2 = reg2_data_i;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_wreg_i[i] && fwd_wd_i[i*REG_AW +: REG_AW] == rs1) op1 = fwd_wdata_i[i*DATA_W +: DATA_W];
      if (fwd_wreg_i[i] && fwd_wd_i[i*REG_AW +: REG_AW] == rs2) op2 = fwd_wdata_i[i*DATA_W +: DATA_W];
    end
    op1 = reg1_read_o ? op1 : imm1;
    op2 = reg2_read_o ? op2 : imm2;
  end

  assign fwd0_wd = fwd_wd_i[REG_AW-1:0];
  assign hazard  = bus.in_valid && ex_is_load_i && fwd_wreg_i[0] &&
                   ((reg1_read_o && fwd0_wd == rs1) || (reg2_read_o && fwd0_wd == rs2));
  assign bus.in_ready = rst && !hazard && (!bus.out_valid || bus.out_ready) && !flush_i;
  assign xfer = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.aluop_o   <= EXE_NOP_OP;
      bus.alusel_o  <= EXE_RES_NOP;
      bus.reg1_o    <= '0;
      bus.reg2_o    <= '0;
      bus.wd_o      <= NOP_REG_ADDR;
      bus.wreg_o    <= 1'b0;
      bus.illegal_o <= 1'b0;
      bus.pc_o      <= '0;
      hazard_cnt_o  <= '0;
    end else begin
      bus.out_valid <= xfer || (bus.out_valid && !bus.out_ready && !flush_i);
      if (hazard && !(&hazard_cnt_o)) hazard_cnt_o <= hazard_cnt_o + CNT_W'(1);
      if (xfer) begin
        bus.aluop_o   <= legal ? op : EXE_NOP_OP;
        bus.alusel_o  <= !legal ? EXE_RES_NOP : is_logic ? EXE_RES_LOGIC : EXE_RES_SHIFT;
        bus.reg1_o    <= op1;
        bus.reg2_o    <= op2;
        bus.wd_o      <= wd;
        bus.wreg_o    <= legal;
        bus.illegal_o <= !legal;
        bus.pc_o      <= bus.pc_i;
      end
    end
  end
endmodule
